bc_instr_sequencer: RTL and testbench

//  Control sequencer for the Basic Computer register file and common bus. Drives the

---
 rtl/bc_instr_sequencer.sv | 128 ++++++++++++
 tb/tb_bc_instr_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bc_instr_sequencer.sv
// bc_instr_sequencer: Basic Computer fetch/decode/indirect/interrupt control sequencer
module bc_instr_sequencer #(
  parameter int WORD     = 16,
  parameter int ADDR     = 12,
  parameter int SC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WORD-1:0]     ir_in,
  input  logic                ien,
  input  logic                int_req,
  input  logic                exec_done,
  input  logic                halt,
  output logic                ar_load,
  output logic                ar_clr,
  output logic                pc_load,
  output logic                pc_incr,
  output logic                pc_clr,
  output logic                ir_load,
  output logic                tr_load,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          bus_sel,
  output logic                ien_clr,
  output logic                exec_start,
  output logic                i_bit,
  output logic [7:0]          dec,
  output logic                r_flag,
  output logic                running,
  output logic [SC_WIDTH-1:0] sc
);
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F0   = 4'd1;
  localparam logic [3:0] S_F1   = 4'd2;
  localparam logic [3:0] S_DEC  = 4'd3;
  localparam logic [3:0] S_IND  = 4'd4;
  localparam logic [3:0] S_EXEC = 4'd5;
  localparam logic [3:0] S_INT0 = 4'd6;
  localparam logic [3:0] S_INT1 = 4'd7;
  localparam logic [3:0] S_INT2 = 4'd8;

  logic [3:0]          r_state;
  logic [3:0]          w_next;
  logic                r_i_bit;
  logic [7:0]          r_dec;
  logic                r_r_flag;
  logic                r_exec_first;
  logic [SC_WIDTH-1:0] r_sc;
  logic [SC_WIDTH-1:0] w_sc_next;
  logic                w_r_set;
  logic                w_r_next;
  logic                w_ind;
  logic                w_unused;

  // Only the opcode/I bits of IR steer sequencing; the address field goes to AR over the bus.
  assign w_unused = (^ir_in[WORD-5:0]) ^ (ADDR == 0);

  // R is armed by a pending interrupt during IND/EXEC and dropped once INT2 has saved PC.
  assign w_r_set  = (r_state == S_IND || r_state == S_EXEC) && ien && int_req;
  assign w_r_next = (r_state == S_INT2) ? 1'b0 : (r_r_flag | w_r_set);

  // Next-state selection; the EXEC exit sees this cycle's R update so a late interrupt is not lost.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_F0 : S_IDLE;
      S_F0:    w_next = S_F1;
      S_F1:    w_next = S_DEC;
      S_DEC:   w_next = S_IND;
      S_IND:   w_next = S_EXEC;
      S_EXEC:  w_next = !exec_done ? S_EXEC : halt ? S_IDLE : w_r_next ? S_INT0 : S_F0;
      S_INT0:  w_next = S_INT1;
      S_INT1:  w_next = S_INT2;
      S_INT2:  w_next = S_F0;
      default: w_next = S_IDLE;
    endcase
  end

  // SC restarts at each instruction/interrupt boundary and saturates during long stalls.
  assign w_sc_next = (w_next == S_IDLE || w_next == S_F0 || w_next == S_INT0) ? '0 :
                     (&r_sc) ? r_sc : r_sc + 1'b1;

  // Sequencer state, decode latches, R flip-flop and sequence counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_i_bit      <= 1'b0;
      r_dec        <= '0;
      r_r_flag     <= 1'b0;
      r_exec_first <= 1'b0;
      r_sc         <= '0;
    end else begin
      r_state      <= w_next;
      r_r_flag     <= w_r_next;
      r_exec_first <= (r_state == S_IND);
      r_sc         <= w_sc_next;
      if (r_state == S_DEC) begin
        r_i_bit <= ir_in[WORD-1];
        r_dec   <= 8'd1 << ir_in[WORD-2:WORD-4];
      end
    end
  end

  // Indirect fetch only for memory-reference opcodes with I set.
  assign w_ind = (r_state == S_IND) && r_i_bit && !r_dec[7];

  assign ar_load    = (r_state == S_F0) || (r_state == S_DEC) || w_ind;
  assign ar_clr     = (r_state == S_INT0);
  assign pc_load    = 1'b0;
  assign pc_incr    = (r_state == S_F1) || (r_state == S_INT2);
  assign pc_clr     = (r_state == S_INT1);
  assign ir_load    = (r_state == S_F1);
  assign tr_load    = (r_state == S_INT0);
  assign mem_read   = (r_state == S_F1) || w_ind;
  assign mem_write  = (r_state == S_INT1);
  assign ien_clr    = (r_state == S_INT2);
  assign exec_start = (r_state == S_EXEC) && r_exec_first;
  assign running    = (r_state != S_IDLE);
  assign bus_sel    = (r_state == S_F0 || r_state == S_INT0) ? 3'd2 :
                      (r_state == S_F1 || w_ind) ? 3'd7 :
                      (r_state == S_DEC) ? 3'd5 :
                      (r_state == S_INT1) ? 3'd6 : 3'd0;
  assign i_bit      = r_i_bit;
  assign dec        = r_dec;
  assign r_flag     = r_r_flag;
  assign sc         = r_sc;
endmodule

// File: tb/tb_bc_instr_sequencer.sv
// tb_bc_instr_sequencer: directed and randomized checks of the instruction sequencer
module tb_bc_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset_n, start, ien, int_req, exec_done, halt;
  logic [15:0] ir_in;
  logic        ar_load, ar_clr, pc_load, pc_incr, pc_clr, ir_load, tr_load;
  logic        mem_read, mem_write, ien_clr, exec_start, i_bit, r_flag, running;
  logic [2:0]  bus_sel;
  logic [7:0]  dec;
  logic [3:0]  sc;

  int checks = 0;
  int failures = 0;
  bit m_r;

  typedef enum int {P_IDLE, P_F0, P_F1, P_DEC, P_IND, P_EXEC, P_INT0, P_INT1, P_INT2} phase_t;

  bc_instr_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir_in(ir_in), .ien(ien),
    .int_req(int_req), .exec_done(exec_done), .halt(halt), .ar_load(ar_load),
    .ar_clr(ar_clr), .pc_load(pc_load), .pc_incr(pc_incr), .pc_clr(pc_clr),
    .ir_load(ir_load), .tr_load(tr_load), .mem_read(mem_read), .mem_write(mem_write),
    .bus_sel(bus_sel), .ien_clr(ien_clr), .exec_start(exec_start), .i_bit(i_bit),
    .dec(dec), .r_flag(r_flag), .running(running), .sc(sc)
  );

  always #5 clk = ~clk;

  wire [14:0] obs_out = {bus_sel, ar_load, ar_clr, pc_load, pc_incr, pc_clr, ir_load,
                         tr_load, mem_read, mem_write, ien_clr, exec_start, running};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] expect_out(phase_t p, bit ind, bit first);
    logic [2:0] b;
    logic al, ac, pi, pc, il, tl, mr, mw, ic, es;
    b = 3'd0;
    {al, ac, pi, pc, il, tl, mr, mw, ic, es} = '0;
    case (p)
      P_F0:   begin b = 3'd2; al = 1'b1; end
      P_F1:   begin b = 3'd7; mr = 1'b1; il = 1'b1; pi = 1'b1; end
      P_DEC:  begin b = 3'd5; al = 1'b1; end
      P_IND:  if (ind) begin b = 3'd7; mr = 1'b1; al = 1'b1; end
      P_EXEC: es = first;
      P_INT0: begin b = 3'd2; ac = 1'b1; tl = 1'b1; end
      P_INT1: begin b = 3'd6; mw = 1'b1; pc = 1'b1; end
      P_INT2: begin pi = 1'b1; ic = 1'b1; end
      default: ;
    endcase
    return {b, al, ac, 1'b0, pi, pc, il, tl, mr, mw, ic, es, p != P_IDLE};
  endfunction

  task automatic check_phase(input string tag, input phase_t p, input int sc_exp,
                             input bit ind = 1'b0, input bit first = 1'b0);
    chk($sformatf("%s.out", tag), 32'(obs_out), 32'(expect_out(p, ind, first)));
    chk($sformatf("%s.sc", tag), 32'(sc), sc_exp);
    chk($sformatf("%s.r", tag), 32'(r_flag), 32'(m_r));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: interrupts quiet; 1: random everywhere; 2: pending only inside the window
  task automatic drive_irq(input int mode, input bit window);
    if (mode == 0) begin ien = 1'b0; int_req = 1'b0; end
    else if (mode == 1) begin ien = 1'($urandom_range(0, 1)); int_req = ($urandom_range(0, 3) == 0); end
    else begin ien = window; int_req = window; end
  endtask

  // Runs one instruction from F0; ends in F0 (after any interrupt) or in IDLE when halted.
  task automatic run_instr(input logic [15:0] ir, input int delay, input bit hlt, input int mode);
    bit ind;
    int s;
    ind = ir[15] && (ir[14:12] != 3'd7);
    check_phase("F0", P_F0, 0);
    ir_in = ir; start = 1'($urandom_range(0, 1)); drive_irq(mode, 1'b0);
    step();
    check_phase("F1", P_F1, 1);
    drive_irq(mode, 1'b0);
    step();
    check_phase("DEC", P_DEC, 2);
    drive_irq(mode, 1'b0);
    step();
    ir_in = 16'($urandom);
    check_phase("IND", P_IND, 3, ind);
    chk("IND.dec", 32'(dec), 32'(1) << ir[14:12]);
    chk("IND.ibit", 32'(i_bit), 32'(ir[15]));
    drive_irq(mode, 1'b0);
    m_r = m_r | (ien & int_req);
    step();
    for (int k = 0; k <= delay; k++) begin
      s = (4 + k > 15) ? 15 : 4 + k;
      check_phase("EXEC", P_EXEC, s, 1'b0, k == 0);
      drive_irq(mode, 1'b1);
      m_r = m_r | (ien & int_req);
      exec_done = (k == delay);
      halt = exec_done ? hlt : 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      step();
    end
    exec_done = 1'b0; halt = 1'b0; start = 1'b0;
    drive_irq(mode, 1'b0);
    if (hlt) begin
      check_phase("HALT", P_IDLE, 0);
    end else if (m_r) begin
      check_phase("INT0", P_INT0, 0);
      drive_irq(mode == 1 ? 1 : 0, 1'b0);
      step();
      check_phase("INT1", P_INT1, 1);
      drive_irq(mode == 1 ? 1 : 0, 1'b0);
      step();
      check_phase("INT2", P_INT2, 2);
      drive_irq(mode == 1 ? 1 : 0, 1'b0);
      step();
      m_r = 1'b0;
    end
  endtask

  task automatic restart();
    start = 1'b0;
    step();
    check_phase("IDLE.hold", P_IDLE, 0);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit hlt;
    reset_n = 1'b0; start = 1'b0; ien = 1'b0; int_req = 1'b0;
    exec_done = 1'b0; halt = 1'b0; ir_in = 16'h0000; m_r = 1'b0;
    #12;
    check_phase("RST", P_IDLE, 0);
    chk("RST.dec", 32'(dec), 0);
    chk("RST.ibit", 32'(i_bit), 0);
    reset_n = 1'b1;
    step();
    check_phase("IDLE", P_IDLE, 0);
    start = 1'b1;
    step();
    start = 1'b0;

    run_instr(16'h2105, 1, 1'b0, 0);
    run_instr(16'hA105, 0, 1'b0, 0);
    run_instr(16'hF400, 0, 1'b0, 0);
    run_instr(16'h7001, 0, 1'b0, 2);
    run_instr(16'h1234, 40, 1'b0, 0);
    run_instr(16'h7001, 2, 1'b1, 0);
    restart();
    run_instr(16'h0001, 0, 1'b1, 2);
    restart();
    run_instr(16'h3000, 0, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      hlt = ($urandom_range(0, 7) == 0);
      run_instr(16'($urandom), int'($urandom_range(0, 20)), hlt, 1);
      if (hlt) restart();
    end

    ir_in = 16'h4321;
    step();
    check_phase("F1.pre_rst", P_F1, 1);
    #2 reset_n = 1'b0;
    #1;
    m_r = 1'b0;
    chk("ARST.out", 32'(obs_out), 0);
    chk("ARST.sc", 32'(sc), 0);
    chk("ARST.r", 32'(r_flag), 0);
    chk("ARST.dec", 32'(dec), 0);
    chk("ARST.ibit", 32'(i_bit), 0);
    #1 reset_n = 1'b1;
    step();
    check_phase("IDLE.post", P_IDLE, 0);
    restart();
    run_instr(16'h9ABC, 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
